riscv_timer_ctrl: RTL and testbench

// Timer front-end for the 64-bit machine time counter. Generates the prescaled incr_en tick

---
 rtl/riscv_timer_ctrl.sv | 136 +++++++++++++
 tb/tb_riscv_timer_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_timer_ctrl.sv
// Machine-timer front-end: prescaled counter tick, 64-bit compare with sticky irq, register port.
// Reads return 1 cycle after i_rd_en, irq rises 2 cycles after match; no backpressure, writes always accepted.
module riscv_timer_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] i_div,
  input  logic [63:0]      i_cnt_value,
  output logic             o_incr_en,
  input  logic             i_wr_en,
  input  logic [2:0]       i_wr_addr,
  input  logic [31:0]      i_wr_data,
  input  logic             i_rd_en,
  input  logic [2:0]       i_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic             o_rd_valid,
  output logic             o_timer_irq
);

  localparam logic [2:0] ADDR_CMP_LO  = 3'd0;
  localparam logic [2:0] ADDR_CMP_HI  = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_TIME_LO = 3'd4;
  localparam logic [2:0] ADDR_TIME_HI = 3'd5;

  logic [63:0]      cmp_q, cmp_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             pending_q, pending_d;
  logic             hold_q, hold_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             incr_q, incr_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             irq_q, irq_d;

  logic wr_lo, wr_hi, wr_ctrl, irq_set, irq_clr;

  always_comb begin
    cmp_d      = cmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    hold_d     = hold_q;
    presc_d    = presc_q;
    shadow_d   = shadow_q;
    incr_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = i_rd_en;
    irq_d      = pending_q & irq_en_q;

    wr_lo   = i_wr_en && (i_wr_addr == ADDR_CMP_LO);
    wr_hi   = i_wr_en && (i_wr_addr == ADDR_CMP_HI);
    wr_ctrl = i_wr_en && (i_wr_addr == ADDR_CTRL);

    if (en_q) begin
      if (presc_q == i_div) begin
        presc_d = '0;
        incr_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end

    // Hold masks the compare while the two halves of a new compare value are being written.
    irq_set   = irq_en_q && !hold_q && (i_cnt_value >= cmp_q);
    irq_clr   = wr_lo || wr_hi || (wr_ctrl && i_wr_data[2]);
    pending_d = irq_clr ? 1'b0 : (pending_q | irq_set);

    if (wr_lo) begin
      cmp_d[31:0] = i_wr_data;
      hold_d      = 1'b1;
    end
    if (wr_hi) begin
      cmp_d[63:32] = i_wr_data;
      hold_d       = 1'b0;
    end
    if (wr_ctrl) begin
      en_d     = i_wr_data[0];
      irq_en_d = i_wr_data[1];
    end

    if (i_rd_en) begin
      case (i_rd_addr)
        ADDR_CMP_LO:  rd_data_d = cmp_q[31:0];
        ADDR_CMP_HI:  rd_data_d = cmp_q[63:32];
        ADDR_CTRL:    rd_data_d = {30'd0, irq_en_q, en_q};
        ADDR_STATUS:  rd_data_d = {30'd0, hold_q, pending_q};
        ADDR_TIME_LO: begin
          rd_data_d = i_cnt_value[31:0];
          shadow_d  = i_cnt_value[63:32];
        end
        ADDR_TIME_HI: rd_data_d = shadow_q;
        default:      rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmp_q      <= '1;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      hold_q     <= 1'b0;
      presc_q    <= '0;
      shadow_q   <= '0;
      incr_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      presc_q    <= presc_d;
      shadow_q   <= shadow_d;
      incr_q     <= incr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign o_incr_en   = incr_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_riscv_timer_ctrl.sv
// Randomized + directed bench for riscv_timer_ctrl with a spec-level reference model and read scoreboard.
module tb_riscv_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] div = 16'd0;
  logic [63:0] cnt = 64'd0;
  logic        incr_en;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        timer_irq;

  riscv_timer_ctrl #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .i_div(div), .i_cnt_value(cnt), .o_incr_en(incr_en),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: register file of the timer, updated once per rising edge.
  logic [63:0] cmp_m;
  logic        en_m, ie_m, pend_m, hold_m;
  logic [31:0] shadow_m;
  int          ticks_m;
  logic        exp_incr, exp_irq, exp_vld;
  logic        started = 1'b0;
  logic [31:0] rdq[$];

  always @(posedge clk) begin
    logic setc, clrc;
    logic [31:0] v;
    started = 1'b1;
    if (!rst) begin
      cmp_m = '1; en_m = 0; ie_m = 0; pend_m = 0; hold_m = 0; shadow_m = 0;
      ticks_m = 0; exp_incr = 0; exp_irq = 0; exp_vld = 0;
      rdq.delete();
    end else begin
      exp_vld = rd_en;
      if (rd_en) begin
        case (rd_addr)
          3'd0: v = cmp_m[31:0];
          3'd1: v = cmp_m[63:32];
          3'd2: v = {30'd0, ie_m, en_m};
          3'd3: v = {30'd0, hold_m, pend_m};
          3'd4: begin v = cnt[31:0]; shadow_m = cnt[63:32]; end
          3'd5: v = shadow_m;
          default: v = 32'd0;
        endcase
        rdq.push_back(v);
      end
      exp_irq = pend_m & ie_m;
      // Tick on every (div+1)-th enabled cycle, counting from the first enabled cycle.
      if (en_m) begin
        exp_incr = ((ticks_m % (int'(div) + 1)) == int'(div));
        ticks_m++;
      end else begin
        exp_incr = 0;
        ticks_m = 0;
      end
      setc = ie_m && !hold_m && (cnt >= cmp_m);
      clrc = wr_en && (wr_addr == 3'd0 || wr_addr == 3'd1 || (wr_addr == 3'd2 && wr_data[2]));
      if (wr_en) begin
        case (wr_addr)
          3'd0: begin cmp_m[31:0] = wr_data; hold_m = 1; end
          3'd1: begin cmp_m[63:32] = wr_data; hold_m = 0; end
          3'd2: begin en_m = wr_data[0]; ie_m = wr_data[1]; end
          default: ;
        endcase
      end
      pend_m = clrc ? 1'b0 : (pend_m | setc);
    end
  end

  // Monitor: per-cycle output checks plus in-order read scoreboard.
  always @(negedge clk) begin
    if (started) begin
      chk("incr_en", incr_en, exp_incr);
      chk("timer_irq", timer_irq, exp_irq);
      chk("rd_valid", rd_valid, exp_vld);
      if (rd_valid === 1'b1) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, rdq.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_en = 1; rd_addr = a;
    step();
    rd_en = 0;
  endtask

  initial begin
    // Reset with register traffic active: must be ignored.
    rst = 0; wr_en = 1; wr_addr = 3'd2; wr_data = 32'h3; rd_en = 1; rd_addr = 3'd0;
    step(2);
    wr_en = 0; rd_en = 0; rst = 1;
    @(negedge clk);
    chk("rst_rd_data", rd_data, 0);
    step();
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3); step(2);

    // Prescaler: div=3, then div=0, then disabled.
    div = 16'd3; wr(3'd2, 32'h1); step(13);
    wr(3'd2, 32'h0); div = 16'd0; step(2);
    wr(3'd2, 32'h1); step(5);
    wr(3'd2, 32'h0); step(3);

    // Irq: cmp=100, count crosses, clear while matching, then move cmp.
    div = 16'd3;
    wr(3'd0, 32'd100); wr(3'd1, 32'd0);
    cnt = 64'd99; wr(3'd2, 32'h3); step(3);
    cnt = 64'd100; step(4);
    rd(3'd3);
    wr(3'd2, 32'h7); step(4);
    wr(3'd0, 32'd200); wr(3'd1, 32'd0); step(3);
    cnt = 64'd199; step(3);
    cnt = 64'd200; step(4);

    // Hold masking.
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'hFFFF_FFFF);
    cnt = 64'h1_0000_0005; step(3);
    wr(3'd0, 32'h0); step(3); rd(3'd3);
    wr(3'd1, 32'h2); step(3);
    wr(3'd0, 32'h0); wr(3'd1, 32'h1); step(4);
    rd(3'd3);

    // Coherent time readout across a 32-bit rollover.
    cnt = 64'h0000_0001_FFFF_FFFF; rd(3'd4);
    cnt = 64'h0000_0002_0000_0000; rd(3'd5);
    rd(3'd6); rd(3'd7); step(2);

    // Reset mid-operation with pending set and prescaler part-way.
    step(2);
    rst = 0; rd_en = 1; rd_addr = 3'd4; step(); rd_en = 0; rst = 1;
    step(2); rd(3'd0); rd(3'd1); rd(3'd3); step(2);

    // Random traffic, fixed divisor.
    div = 16'd2;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) cnt = cnt + 1;
      else if (r < 80) cnt = {32'd0, 32'($urandom_range(0, 400))};
      else if (r < 90) cnt = {$urandom, $urandom};
      wr_en = ($urandom_range(0, 4) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = (wr_addr == 3'd1) ? 32'($urandom_range(0, 1)) :
                (wr_addr == 3'd0) ? 32'($urandom_range(0, 400)) : $urandom;
      rd_en = ($urandom_range(0, 2) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) != 0);
      step();
    end
    wr_en = 0; rd_en = 0; rst = 1;
    step(4);
    chk("rdq_drained", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
